// File: rtl/mc_bus_transmitter.sv
// Transmit end of the global multicast bus: programs one tag per PE, then streams tagged words.
// Optional build macro TX_STALL_CNT_EN adds stall_cnt_o, a saturating count of stalled bus cycles.
module mc_bus_transmitter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned NUM_PE     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_start_i,
    input  logic [TAG_WIDTH-1:0]  cfg_tag_i,
    output logic                  cfg_ack_o,
    output logic [IW-1:0]         cfg_idx_o,
    output logic                  cfg_done_o,
    input  logic [NUM_PE-1:0]     tag_lock_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic [TAG_WIDTH-1:0]  s_tag_i,
    input  logic                  flush_i,
    output logic                  bus_valid_o,
    output logic                  bus_cfg_o,
    output logic [IW-1:0]         bus_id_o,
    output logic [TAG_WIDTH-1:0]  bus_tag_o,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    input  logic                  bus_ready_i
`ifdef TX_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StCfgSend, StCfgWait, StStream} state_e;

    state_e                state_q;
    logic [IW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem_q  [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;

    logic in_stream, fifo_full, fifo_empty, push, pop, lock_hit;

    assign in_stream  = (state_q == StStream);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = in_stream && !flush_i && !fifo_full && s_valid_i;
    assign pop        = in_stream && !fifo_empty && bus_ready_i;
    assign lock_hit   = (state_q == StCfgWait) && tag_lock_i[idx_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfg_start_i) begin
                        state_q <= StCfgSend;
                        idx_q   <= '0;
                    end
                end
                StCfgSend: begin
                    if (bus_ready_i) state_q <= StCfgWait;
                end
                StCfgWait: begin
                    if (lock_hit) begin
                        if (idx_q == IW'(NUM_PE - 1)) begin
                            state_q <= StStream;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= StCfgSend;
                        end
                    end
                end
                StStream: begin
                    if (flush_i && fifo_empty) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            // Power-of-two depth lets the pointers wrap naturally.
            if (push) begin
                data_mem_q[wr_ptr_q] <= s_data_i;
                tag_mem_q[wr_ptr_q]  <= s_tag_i;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_comb begin
        s_ready_o   = in_stream && !flush_i && !fifo_full;
        cfg_ack_o   = lock_hit;
        cfg_idx_o   = idx_q;
        cfg_done_o  = in_stream;
        bus_valid_o = 1'b0;
        bus_cfg_o   = 1'b0;
        bus_id_o    = '0;
        bus_tag_o   = '0;
        bus_data_o  = '0;
        unique case (state_q)
            StCfgSend: begin
                bus_valid_o = 1'b1;
                bus_cfg_o   = 1'b1;
                bus_id_o    = idx_q;
                bus_tag_o   = cfg_tag_i;
            end
            StStream: begin
                if (!fifo_empty) begin
                    bus_valid_o = 1'b1;
                    bus_tag_o   = tag_mem_q[rd_ptr_q];
                    bus_data_o  = data_mem_q[rd_ptr_q];
                end
            end
            default: ;
        endcase
    end

`ifdef TX_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || cfg_start_i) begin
            stall_cnt_q <= '0;
        end else if (in_stream && !fifo_empty && !bus_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mc_bus_transmitter.sv
// Scoreboard bench for mc_bus_transmitter: config sequencing, streaming order, backpressure,
// flush and reset; stall counter covered when TX_STALL_CNT_EN is defined.
module tb_mc_bus_transmitter;

    localparam int unsigned DW = 16;
    localparam int unsigned TW = 4;
    localparam int unsigned NP = 16;
    localparam int unsigned FD = 4;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic [TW-1:0] cfg_tag;
    logic          cfg_ack;
    logic [IW-1:0] cfg_idx;
    logic          cfg_done;
    logic [NP-1:0] tag_lock;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [TW-1:0] s_tag;
    logic          flush;
    logic          bus_valid;
    logic          bus_cfg;
    logic [IW-1:0] bus_id;
    logic [TW-1:0] bus_tag;
    logic [DW-1:0] bus_data;
    logic          bus_ready;
`ifdef TX_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    mc_bus_transmitter #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .NUM_PE     (NP),
        .FIFO_DEPTH (FD)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_start_i (cfg_start),
        .cfg_tag_i   (cfg_tag),
        .cfg_ack_o   (cfg_ack),
        .cfg_idx_o   (cfg_idx),
        .cfg_done_o  (cfg_done),
        .tag_lock_i  (tag_lock),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .s_data_i    (s_data),
        .s_tag_i     (s_tag),
        .flush_i     (flush),
        .bus_valid_o (bus_valid),
        .bus_cfg_o   (bus_cfg),
        .bus_id_o    (bus_id),
        .bus_tag_o   (bus_tag),
        .bus_data_o  (bus_data),
        .bus_ready_i (bus_ready)
`ifdef TX_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } word_t;

    word_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    pop_cnt = 0;
    int    ack_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: FIFO occupancy equals scoreboard depth; head must match every valid cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (cfg_ack) ack_cnt++;
            if (cfg_done) begin
                check_eq("bus_valid_vs_count", 64'(bus_valid), 64'(sb.size() != 0));
                check_eq("s_ready_vs_count", 64'(s_ready), 64'(!flush && (sb.size() != FD)));
                if (bus_valid && (sb.size() != 0)) begin
                    check_eq("stream_bus_cfg", 64'(bus_cfg), 64'd0);
                    check_eq("stream_bus_id", 64'(bus_id), 64'd0);
                    check_eq("stream_bus_data", 64'(bus_data), 64'(sb[0].data));
                    check_eq("stream_bus_tag", 64'(bus_tag), 64'(sb[0].tag));
                    if (bus_ready) begin
                        void'(sb.pop_front());
                        pop_cnt++;
                    end
                end
                if (s_valid && s_ready) sb.push_back('{tag: s_tag, data: s_data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_words(input int n, input logic [DW-1:0] base);
        for (int w = 0; w < n; w++) begin
            bit ok;
            ok      = 1'b0;
            s_valid = 1'b1;
            s_data  = base + DW'(w);
            s_tag   = TW'(w * 3 + 1);
            for (int c = 0; c < 50 && !ok; c++) begin
                @(negedge clk);
                ok = s_ready;
                tick();
            end
            if (!ok) check_eq("push_timeout", 64'd0, 64'd1);
        end
        s_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) tick();
        check_eq("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_config();
        bit ok;
        tag_lock  = '0;
        ack_cnt   = 0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < NP; i++) begin
            cfg_tag = TW'(NP - 1 - i);
            ok = 1'b0;
            for (int c = 0; c < 20 && !ok; c++) begin
                @(negedge clk);
                ok = bus_valid && bus_cfg;
                if (!ok) tick();
            end
            check_eq("cfg_send_seen", 64'(ok), 64'd1);
            check_eq("cfg_bus_id", 64'(bus_id), 64'(i));
            check_eq("cfg_bus_tag", 64'(bus_tag), 64'(NP - 1 - i));
            check_eq("cfg_bus_data", 64'(bus_data), 64'd0);
            check_eq("cfg_done_early", 64'(cfg_done), 64'd0);
            tick();
            @(negedge clk);
            check_eq("cfg_wait_bus_idle", 64'(bus_valid), 64'd0);
            check_eq("cfg_ack_early", 64'(cfg_ack), 64'd0);
            tick();
            tag_lock[i] = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 20 && !ok; c++) begin
                @(negedge clk);
                ok = cfg_ack;
                tick();
            end
            check_eq("cfg_ack_seen", 64'(ok), 64'd1);
        end
        @(negedge clk);
        check_eq("cfg_ack_count", 64'(ack_cnt), 64'(NP));
        check_eq("cfg_done_after", 64'(cfg_done), 64'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_tag   = '0;
        tag_lock  = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_tag     = '0;
        flush     = 1'b0;
        bus_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check_eq("rst_bus_valid", 64'(bus_valid), 64'd0);
        check_eq("rst_s_ready", 64'(s_ready), 64'd0);
        check_eq("rst_cfg_done", 64'(cfg_done), 64'd0);
        check_eq("rst_cfg_ack", 64'(cfg_ack), 64'd0);
        check_eq("rst_cfg_idx", 64'(cfg_idx), 64'd0);
        tick();
        rst     = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'hFFFF;
        tick();
        @(negedge clk);
        check_eq("idle_s_ready", 64'(s_ready), 64'd0);
        check_eq("idle_bus_valid", 64'(bus_valid), 64'd0);
        tick();
        s_valid = 1'b0;

        run_config();

        // Backpressure: FIFO fills after four words, then drains in order.
        bus_ready = 1'b0;
        drive_words(4, 16'hA001);
        s_valid = 1'b1;
        s_data  = 16'hA005;
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_full_s_ready", 64'(s_ready), 64'd0);
            tick();
        end
        p0        = pop_cnt;
        bus_ready = 1'b1;
        drive_words(2, 16'hA005);
        drain(20);
        check_eq("bp_pop_total", 64'(pop_cnt - p0), 64'd6);

        // Simultaneous push/pop at occupancy two.
        bus_ready = 1'b0;
        drive_words(2, 16'hB001);
        p0        = pop_cnt;
        bus_ready = 1'b1;
        drive_words(10, 16'hB101);
        check_eq("simul_pops", 64'(pop_cnt - p0), 64'd10);
        check_eq("simul_depth", 64'(sb.size()), 64'd2);
        drain(10);

        // Flush: three words drain, IDLE on the fourth cycle.
        bus_ready = 1'b0;
        drive_words(3, 16'hC001);
        flush     = 1'b1;
        s_valid   = 1'b1;
        s_data    = 16'hCFFF;
        bus_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("flush_in_stream", 64'(cfg_done), 64'd1);
            check_eq("flush_s_ready", 64'(s_ready), 64'd0);
            tick();
        end
        @(negedge clk);
        check_eq("flush_idle", 64'(cfg_done), 64'd0);
        check_eq("flush_bus_valid", 64'(bus_valid), 64'd0);
        check_eq("flush_drained", 64'(sb.size()), 64'd0);
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;

        run_config();
`ifdef TX_STALL_CNT_EN
        check_eq("stall_after_cfg", 64'(stall_cnt), 64'd0);
        bus_ready = 1'b0;
        drive_words(1, 16'hE001);
        repeat (7) tick();
        bus_ready = 1'b1;
        drain(10);
        @(negedge clk);
        check_eq("stall_cnt_7", 64'(stall_cnt), 64'd7);
        tick();
`endif
        // cfg_start outside IDLE leaves the FSM in STREAM.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        @(negedge clk);
        check_eq("cfg_start_ignored", 64'(cfg_done), 64'd1);
        check_eq("cfg_start_no_cfg", 64'(bus_cfg), 64'd0);
`ifdef TX_STALL_CNT_EN
        check_eq("stall_cleared", 64'(stall_cnt), 64'd0);
`endif
        tick();

        // Reset with three words queued.
        bus_ready = 1'b0;
        drive_words(3, 16'hD001);
        rst = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check_eq("midrst_bus_valid", 64'(bus_valid), 64'd0);
        check_eq("midrst_s_ready", 64'(s_ready), 64'd0);
        check_eq("midrst_cfg_done", 64'(cfg_done), 64'd0);
        tick();
        rst       = 1'b0;
        bus_ready = 1'b1;
        run_config();
        @(negedge clk);
        check_eq("post_rst_empty", 64'(bus_valid), 64'd0);
        tick();
        drive_words(2, 16'hF001);
        drain(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
